// File: rtl/swipt_period_calc.sv
// -----------------------------------------------------------------------------
// swipt_period_calc
//
// Configuration front end for the SWIPT full-bridge driver. A request of
// (frequency in Hz, duty in per-mille) is validated, the duty is clamped to
// MAX_DUTY_PM, and the driver timing is derived with two sequential restoring
// dividers:
//     period_cycles = floor(CLK_HZ / freq)
//     half_cycles   = period_cycles >> 1
//     pulse_cycles  = floor(period_cycles * duty / 1000)
// The whole set is published in a single cycle so the driver never sees a
// mix of old and new values.
//
// Ports
//   clk, nrst        clock (rising edge) and asynchronous active-low reset
//   enable           master enable; gates swipt_alive only
//   req_valid/ready  request handshake (ready only while idle)
//   req_freq         requested frequency, Hz
//   req_duty         requested duty, per-mille (clamped to MAX_DUTY_PM)
//   freq_out, l_out  published frequency and clamped duty
//   period_cycles    published period in clock cycles
//   half_cycles      published half period
//   pulse_cycles     published pulse length
//   cfg_valid        one-cycle strobe when the published set updates
//   clamped          duty of the published set was clamped
//   err, err_code    one-cycle reject strobe; code 01 zero freq,
//                    10 period out of range (code held until next reject)
//   swipt_alive      enable and at least one config published since reset
//
// Timing (accepting edge = edge 0)
//   zero frequency   err high after edge 0
//   range reject     err high after edge 30
//   success          cfg_valid high after edge 57
// -----------------------------------------------------------------------------
module swipt_period_calc #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned MIN_PERIOD  = 32,
    parameter int unsigned MAX_PERIOD  = 8191,
    parameter int unsigned MAX_DUTY_PM = 480
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        enable,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_freq,
    input  logic [11:0] req_duty,
    output logic [31:0] freq_out,
    output logic [11:0] l_out,
    output logic [12:0] period_cycles,
    output logic [11:0] half_cycles,
    output logic [11:0] pulse_cycles,
    output logic        cfg_valid,
    output logic        clamped,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        swipt_alive
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV_P,
        ST_MUL,
        ST_DIV_L,
        ST_CHECK,
        ST_PUBLISH
    } state_t;

    localparam logic [27:0] DIVIDEND   = 28'(CLK_HZ);
    localparam logic [27:0] PER_MIN    = 28'(MIN_PERIOD);
    localparam logic [27:0] PER_MAX    = 28'(MAX_PERIOD);
    localparam logic [11:0] DUTY_MAX   = 12'(MAX_DUTY_PM);
    localparam logic [10:0] L_DIVISOR  = 11'd1000;
    // DIV_P spends 28 shift steps plus one capture cycle (count 28) where the
    // quotient is registered and range-checked, keeping the compare off the
    // subtractor path.
    localparam logic [4:0]  P_CAPTURE  = 5'd28;
    localparam logic [4:0]  L_LAST     = 5'd24;

    state_t state_reg;
    state_t state_next;

    // Latched request operands
    logic [31:0] freq_lat_reg;
    logic [11:0] duty_lat_reg;
    logic        clamp_lat_reg;

    // Period divider: CLK_HZ / freq
    logic [27:0] p_num_reg;
    logic [28:0] p_rem_reg;
    logic [27:0] p_quo_reg;
    logic [4:0]  step_cnt_reg;

    // Intermediate results
    logic [12:0] period_reg;
    logic        range_bad_reg;
    logic [11:0] half_reg;

    // Pulse divider: (period * duty) / 1000
    logic [24:0] l_num_reg;
    logic [9:0]  l_rem_reg;
    logic [11:0] l_quo_reg;     // quotient < 4096, upper bits never set

    // Published set and status
    logic [31:0] freq_out_reg;
    logic [11:0] l_out_reg;
    logic [12:0] period_out_reg;
    logic [11:0] half_out_reg;
    logic [11:0] pulse_out_reg;
    logic        cfg_valid_reg;
    logic        clamped_reg;
    logic        err_reg;
    logic        zero_err_reg;
    logic [1:0]  err_code_reg;
    logic        published_reg;

    logic        accept;
    logic [11:0] duty_clamped;
    logic        duty_over;

    // Restoring divider step signals
    logic [28:0] p_shift;
    logic        p_ge;
    logic [28:0] p_diff;
    logic [10:0] l_shift;
    logic        l_ge;
    logic [10:0] l_diff;
    logic [24:0] product;

    // The zero-frequency reject is answered from IDLE, so the one cycle that
    // carries its err pulse also withholds ready.
    assign req_ready = (state_reg == ST_IDLE) && !zero_err_reg;
    assign accept    = req_valid && req_ready;

    assign duty_over    = (req_duty > DUTY_MAX);
    assign duty_clamped = duty_over ? DUTY_MAX : req_duty;

    // Remainder stays below the divisor and below 2^28, so a 29-bit shifted
    // remainder is enough and the difference fits when p_ge is set.
    assign p_shift = {p_rem_reg[27:0], p_num_reg[27]};
    assign p_ge    = ({3'b000, p_shift} >= freq_lat_reg);
    assign p_diff  = p_shift - freq_lat_reg[28:0];

    assign l_shift = {l_rem_reg, l_num_reg[24]};
    assign l_ge    = (l_shift >= L_DIVISOR);
    assign l_diff  = l_shift - L_DIVISOR;

    assign product = 25'(period_reg) * 25'(duty_lat_reg);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept && (req_freq != 32'd0)) begin
                    state_next = ST_DIV_P;
                end
            end
            ST_DIV_P: begin
                if (step_cnt_reg == P_CAPTURE) begin
                    state_next = ST_MUL;
                end
            end
            ST_MUL: begin
                state_next = range_bad_reg ? ST_IDLE : ST_DIV_L;
            end
            ST_DIV_L: begin
                if (step_cnt_reg == L_LAST) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK:   state_next = ST_PUBLISH;
            ST_PUBLISH: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            freq_lat_reg   <= '0;
            duty_lat_reg   <= '0;
            clamp_lat_reg  <= 1'b0;
            p_num_reg      <= '0;
            p_rem_reg      <= '0;
            p_quo_reg      <= '0;
            step_cnt_reg   <= '0;
            period_reg     <= '0;
            range_bad_reg  <= 1'b0;
            half_reg       <= '0;
            l_num_reg      <= '0;
            l_rem_reg      <= '0;
            l_quo_reg      <= '0;
            freq_out_reg   <= '0;
            l_out_reg      <= '0;
            period_out_reg <= '0;
            half_out_reg   <= '0;
            pulse_out_reg  <= '0;
            cfg_valid_reg  <= 1'b0;
            clamped_reg    <= 1'b0;
            err_reg        <= 1'b0;
            zero_err_reg   <= 1'b0;
            err_code_reg   <= 2'b00;
            published_reg  <= 1'b0;
        end else begin
            // Strobes last exactly one cycle
            cfg_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            zero_err_reg  <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        freq_lat_reg  <= req_freq;
                        duty_lat_reg  <= duty_clamped;
                        clamp_lat_reg <= duty_over;
                        p_num_reg     <= DIVIDEND;
                        p_rem_reg     <= '0;
                        p_quo_reg     <= '0;
                        step_cnt_reg  <= '0;
                        if (req_freq == 32'd0) begin
                            err_reg      <= 1'b1;
                            zero_err_reg <= 1'b1;
                            err_code_reg <= 2'b01;
                        end
                    end
                end

                ST_DIV_P: begin
                    if (step_cnt_reg == P_CAPTURE) begin
                        period_reg    <= p_quo_reg[12:0];
                        range_bad_reg <= (p_quo_reg > PER_MAX) || (p_quo_reg < PER_MIN);
                    end else begin
                        p_num_reg    <= {p_num_reg[26:0], 1'b0};
                        p_rem_reg    <= p_ge ? p_diff : p_shift;
                        p_quo_reg    <= {p_quo_reg[26:0], p_ge};
                        step_cnt_reg <= step_cnt_reg + 5'd1;
                    end
                end

                ST_MUL: begin
                    if (range_bad_reg) begin
                        err_reg      <= 1'b1;
                        err_code_reg <= 2'b10;
                    end else begin
                        l_num_reg    <= product;
                        l_rem_reg    <= '0;
                        l_quo_reg    <= '0;
                        step_cnt_reg <= '0;
                    end
                end

                ST_DIV_L: begin
                    l_num_reg    <= {l_num_reg[23:0], 1'b0};
                    l_rem_reg    <= l_ge ? l_diff[9:0] : l_shift[9:0];
                    l_quo_reg    <= {l_quo_reg[10:0], l_ge};
                    step_cnt_reg <= step_cnt_reg + 5'd1;
                end

                ST_CHECK: begin
                    half_reg <= period_reg[12:1];
                end

                ST_PUBLISH: begin
                    freq_out_reg   <= freq_lat_reg;
                    l_out_reg      <= duty_lat_reg;
                    period_out_reg <= period_reg;
                    half_out_reg   <= half_reg;
                    pulse_out_reg  <= l_quo_reg;
                    clamped_reg    <= clamp_lat_reg;
                    cfg_valid_reg  <= 1'b1;
                    published_reg  <= 1'b1;
                end

                default: begin
                end
            endcase
        end
    end

    assign freq_out      = freq_out_reg;
    assign l_out         = l_out_reg;
    assign period_cycles = period_out_reg;
    assign half_cycles   = half_out_reg;
    assign pulse_cycles  = pulse_out_reg;
    assign cfg_valid     = cfg_valid_reg;
    assign clamped       = clamped_reg;
    assign err           = err_reg;
    assign err_code      = err_code_reg;
    assign swipt_alive   = enable && published_reg;

endmodule

// File: tb/tb_swipt_period_calc.sv
// Directed bench for swipt_period_calc: a table of requests with
// hand-computed timing and results, plus sequences for back-pressure,
// enable gating and reset during a computation.
module tb_swipt_period_calc;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        enable = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_freq = '0;
    logic [11:0] req_duty = '0;
    logic [31:0] freq_out;
    logic [11:0] l_out;
    logic [12:0] period_cycles;
    logic [11:0] half_cycles;
    logic [11:0] pulse_cycles;
    logic        cfg_valid;
    logic        clamped;
    logic        err;
    logic [1:0]  err_code;
    logic        swipt_alive;

    swipt_period_calc dut (
        .clk           (clk),
        .nrst          (nrst),
        .enable        (enable),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_freq      (req_freq),
        .req_duty      (req_duty),
        .freq_out      (freq_out),
        .l_out         (l_out),
        .period_cycles (period_cycles),
        .half_cycles   (half_cycles),
        .pulse_cycles  (pulse_cycles),
        .cfg_valid     (cfg_valid),
        .clamped       (clamped),
        .err           (err),
        .err_code      (err_code),
        .swipt_alive   (swipt_alive)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] freq;
        logic [11:0] duty;
        int          lat;     // offset of cfg_valid/err after accepting edge
        logic [1:0]  code;    // 00 = success
        logic [12:0] per;
        logic [11:0] half;
        logic [11:0] pulse;
        logic [11:0] l;
        logic        clamp;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    // Expected published state
    logic [31:0] e_freq;
    logic [11:0] e_l, e_half, e_pulse;
    logic [12:0] e_per;
    logic        e_clamp;
    logic [1:0]  e_code;
    logic        e_pub;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            step();
            n++;
        end
        chk("ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic check_published(input string tag);
        chk({tag, "_freq"},   freq_out,      e_freq);
        chk({tag, "_l"},      {20'd0, l_out}, {20'd0, e_l});
        chk({tag, "_period"}, {19'd0, period_cycles}, {19'd0, e_per});
        chk({tag, "_half"},   {20'd0, half_cycles}, {20'd0, e_half});
        chk({tag, "_pulse"},  {20'd0, pulse_cycles}, {20'd0, e_pulse});
        chk({tag, "_clamped"}, {31'd0, clamped}, {31'd0, e_clamp});
        chk({tag, "_err_code"}, {30'd0, err_code}, {30'd0, e_code});
        chk({tag, "_alive"}, {31'd0, swipt_alive}, {31'd0, (e_pub & enable)});
    endtask

    // Issue one request, find the offset of the first cfg_valid/err strobe,
    // then compare the published set with the model.
    task automatic run_vec(input vec_t v, input string tag);
        int seen;
        logic got_err;
        logic got_cfg;
        wait_ready();
        req_freq  = v.freq;
        req_duty  = v.duty;
        req_valid = 1'b1;
        step();                 // accepting edge = offset 0
        req_valid = 1'b0;
        seen = -1;
        got_err = 1'b0;
        got_cfg = 1'b0;
        for (int n = 0; n <= 70; n++) begin
            if (n > 0) step();
            if (cfg_valid || err) begin
                seen = n;
                got_err = err;
                got_cfg = cfg_valid;
                break;
            end
        end
        chk({tag, "_latency"}, seen, v.lat);
        if (v.code == 2'b00) begin
            chk({tag, "_cfg_valid"}, {31'd0, got_cfg}, 32'd1);
            e_freq  = v.freq;
            e_l     = v.l;
            e_per   = v.per;
            e_half  = v.half;
            e_pulse = v.pulse;
            e_clamp = v.clamp;
            e_pub   = 1'b1;
        end else begin
            chk({tag, "_err"}, {31'd0, got_err}, 32'd1);
            chk({tag, "_no_cfg"}, {31'd0, got_cfg}, 32'd0);
            e_code = v.code;
        end
        check_published(tag);
    endtask

    initial begin
        int busy_ready;
        int seen;

        //           freq          duty    lat code  per      half     pulse    l        clamp
        vecs[0]  = '{32'd100000,   12'd400,  57, 2'b00, 13'd1000, 12'd500,  12'd400,  12'd400, 1'b0};
        vecs[1]  = '{32'd0,        12'd100,   0, 2'b01, 13'd0,    12'd0,    12'd0,    12'd0,   1'b0};
        vecs[2]  = '{32'd10000,    12'd100,  30, 2'b10, 13'd0,    12'd0,    12'd0,    12'd0,   1'b0};
        vecs[3]  = '{32'd4000000,  12'd100,  30, 2'b10, 13'd0,    12'd0,    12'd0,    12'd0,   1'b0};
        vecs[4]  = '{32'd100000,   12'd900,  57, 2'b00, 13'd1000, 12'd500,  12'd480,  12'd480, 1'b1};
        vecs[5]  = '{32'd333333,   12'd250,  57, 2'b00, 13'd300,  12'd150,  12'd75,   12'd250, 1'b0};
        vecs[6]  = '{32'd12208,    12'd480,  57, 2'b00, 13'd8191, 12'd4095, 12'd3931, 12'd480, 1'b0};
        vecs[7]  = '{32'd12207,    12'd480,  30, 2'b10, 13'd0,    12'd0,    12'd0,    12'd0,   1'b0};
        vecs[8]  = '{32'd3125000,  12'd480,  57, 2'b00, 13'd32,   12'd16,   12'd15,   12'd480, 1'b0};
        vecs[9]  = '{32'd3125001,  12'd480,  30, 2'b10, 13'd0,    12'd0,    12'd0,    12'd0,   1'b0};
        vecs[10] = '{32'd200000,   12'd0,    57, 2'b00, 13'd500,  12'd250,  12'd0,    12'd0,   1'b0};
        vecs[11] = '{32'd1000000,  12'd4095, 57, 2'b00, 13'd100,  12'd50,   12'd48,   12'd480, 1'b1};
        vecs[12] = '{32'hFFFFFFFF, 12'd10,   30, 2'b10, 13'd0,    12'd0,    12'd0,    12'd0,   1'b0};

        e_freq = '0; e_l = '0; e_per = '0; e_half = '0; e_pulse = '0;
        e_clamp = 1'b0; e_code = 2'b00; e_pub = 1'b0;

        // Reset state
        #23;
        chk("rst_alive_in_reset", {31'd0, swipt_alive}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        step();
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_cfg_valid", {31'd0, cfg_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        check_published("rst");

        // Table-driven requests
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            $display("vec%0d freq=%0d duty=%0d period=%0d half=%0d pulse=%0d l=%0d clamped=%0d err_code=%0d",
                     i, vecs[i].freq, vecs[i].duty, period_cycles, half_cycles,
                     pulse_cycles, l_out, clamped, err_code);
        end

        // Request held during busy: second one waits, first uses its own operands
        wait_ready();
        req_freq  = 32'd333333;
        req_duty  = 12'd250;
        req_valid = 1'b1;
        step();                                 // accept A, offset 0
        req_freq  = 32'd100000;
        req_duty  = 12'd400;
        busy_ready = 0;
        seen = -1;
        for (int n = 1; n <= 57; n++) begin
            step();
            if (req_ready && n < 57) busy_ready++;
            if (cfg_valid && seen < 0) seen = n;
        end
        chk("busy_ready_low", busy_ready, 0);
        chk("busy_a_latency", seen, 57);
        e_freq = 32'd333333; e_l = 12'd250; e_per = 13'd300; e_half = 12'd150;
        e_pulse = 12'd75; e_clamp = 1'b0; e_pub = 1'b1;
        check_published("busy_a");
        chk("busy_ready_back", {31'd0, req_ready}, 32'd1);
        step();                                 // accept B, offset 0
        req_valid = 1'b0;
        chk("busy_b_taken", {31'd0, req_ready}, 32'd0);
        seen = -1;
        for (int n = 1; n <= 70; n++) begin
            step();
            if (cfg_valid) begin
                seen = n;
                break;
            end
        end
        chk("busy_b_latency", seen, 57);
        e_freq = 32'd100000; e_l = 12'd400; e_per = 13'd1000; e_half = 12'd500;
        e_pulse = 12'd400;
        check_published("busy_b");
        $display("busy sequence freq=%0d period=%0d pulse=%0d", freq_out, period_cycles, pulse_cycles);

        // Enable gates only swipt_alive
        enable = 1'b0;
        #1;
        chk("enable_low_alive", {31'd0, swipt_alive}, 32'd0);
        chk("enable_low_period", {19'd0, period_cycles}, 32'd1000);
        enable = 1'b1;
        #1;
        chk("enable_high_alive", {31'd0, swipt_alive}, 32'd1);
        $display("enable toggle alive=%0d", swipt_alive);

        // Reset in the middle of a computation
        wait_ready();
        req_freq  = 32'd333333;
        req_duty  = 12'd250;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int n = 1; n <= 20; n++) step();
        nrst = 1'b0;
        #1;
        e_freq = '0; e_l = '0; e_per = '0; e_half = '0; e_pulse = '0;
        e_clamp = 1'b0; e_code = 2'b00; e_pub = 1'b0;
        check_published("midrst");
        @(negedge clk);
        nrst = 1'b1;
        step();
        chk("midrst_no_cfg", {31'd0, cfg_valid}, 32'd0);
        run_vec(vecs[0], "after_rst");
        $display("after reset freq=%0d period=%0d pulse=%0d alive=%0d",
                 freq_out, period_cycles, pulse_cycles, swipt_alive);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
